// File: rtl/call_stack_unit.sv
// call_stack_unit: LIFO for return addresses, segment values and general data.
// The top of stack is presented combinationally, so a POP/RET completes in
// the cycle it is issued. Pushes become visible one cycle later.
// Optional feature: define CALL_STACK_WATERMARK_EN to add the HIGH_WATER
// output, which tracks the deepest SP reached since reset or the last CLR_ERR.
module call_stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              CALL,
  input  logic              SEG_PUSH,
  input  logic [DATA_W-1:0] IP_IN,
  input  logic [DATA_W-1:0] SEGMENT_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] POP_DATA,
  output logic              EMPTY,
  output logic              FULL,
  output logic [PTR_W:0]    SP,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  input  logic              CLR_ERR
`ifdef CALL_STACK_WATERMARK_EN
  ,
  output logic [PTR_W:0]    HIGH_WATER
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    sp;
  logic [PTR_W:0]    sp_next;
  logic [PTR_W-1:0]  top_idx;
  logic [DATA_W-1:0] push_val;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_replace;
  logic              ovf_set;
  logic              unf_set;
  logic              ovf;
  logic              unf;

  // Counts are decoded from the registered pointer only.
  assign empty   = (sp == '0);
  assign full    = (sp == (PTR_W+1)'(DEPTH));
  // Wraps correctly at SP=DEPTH because the low bits are then zero.
  assign top_idx = sp[PTR_W-1:0] - PTR_W'(1);

  // Push value selection; CALL outranks SEG_PUSH, return address is IP+1.
  always_comb begin
    push_val = DATA_IN;
    if (CALL)
      push_val = IP_IN + DATA_W'(1);
    else if (SEG_PUSH)
      push_val = SEGMENT_IN;
  end

  // Decide the stack operation for this cycle and the next pointer value.
  always_comb begin
    do_push    = 1'b0;
    do_replace = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    sp_next    = sp;
    if (PUSH && POP) begin
      if (empty) begin
        // Nothing to pop: behaves as a plain push but still flags underflow.
        do_push = 1'b1;
        unf_set = 1'b1;
        sp_next = sp + (PTR_W+1)'(1);
      end else begin
        do_replace = 1'b1;
      end
    end else if (PUSH) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        do_push = 1'b1;
        sp_next = sp + (PTR_W+1)'(1);
      end
    end else if (POP) begin
      if (empty)
        unf_set = 1'b1;
      else
        sp_next = sp - (PTR_W+1)'(1);
    end
  end

  // Storage array; contents are meaningless after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (do_push)
      mem[sp[PTR_W-1:0]] <= push_val;
    else if (do_replace)
      mem[top_idx] <= push_val;
  end

  // Stack pointer register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      sp <= '0;
    else
      sp <= sp_next;
  end

  // Sticky error flags; a clear wins over a same-cycle error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (CLR_ERR) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

`ifdef CALL_STACK_WATERMARK_EN
  logic [PTR_W:0] high_water;

  // Deepest pointer seen; CLR_ERR rebases it to the present depth.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      high_water <= '0;
    else if (CLR_ERR)
      high_water <= sp;
    else if (sp_next > high_water)
      high_water <= sp_next;
  end

  assign HIGH_WATER = high_water;
`endif

  assign POP_DATA  = empty ? '0 : mem[top_idx];
  assign EMPTY     = empty;
  assign FULL      = full;
  assign SP        = sp;
  assign OVERFLOW  = ovf;
  assign UNDERFLOW = unf;

endmodule
